// File: rtl/jelly3_img_region_rect_scheduler.sv
// Region-rect scheduler: keeps a small table of crop rectangles and, at each
// frame start, picks the next eligible one in round-robin order (with an
// optional multi-frame hold). It clamps the rectangle to the incoming image
// size. All outputs are registered and change only on a frame-start edge.

// Per-entry lane: checks eligibility against the current image size and
// produces the clamped width/height. All logic in this module is combinational.
module jelly3_img_region_rect_scheduler_unit #(
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10
) (
  input  logic              en,
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [X_BITS-1:0] width,
  input  logic [Y_BITS-1:0] height,
  input  logic [X_BITS-1:0] img_cols,
  input  logic [Y_BITS-1:0] img_rows,
  output logic              eligible,
  output logic [X_BITS-1:0] clamp_w,
  output logic [Y_BITS-1:0] clamp_h
);

  // Remaining space to the image edge. The extra bit keeps x+width from wrapping.
  logic [X_BITS:0] rem_x;
  logic [Y_BITS:0] rem_y;

  // Eligibility test and min() clamp. The result only matters while the entry is eligible.
  always_comb begin
    rem_x    = {1'b0, img_cols} - {1'b0, x};
    rem_y    = {1'b0, img_rows} - {1'b0, y};
    eligible = en && (x < img_cols) && (y < img_rows) && (width != '0) && (height != '0);
    clamp_w  = ({1'b0, width}  < rem_x) ? width  : rem_x[X_BITS-1:0];
    clamp_h  = ({1'b0, height} < rem_y) ? height : rem_y[Y_BITS-1:0];
  end

endmodule

module jelly3_img_region_rect_scheduler #(
  parameter int N         = 4,
  parameter int IDX_BITS  = (N > 1) ? $clog2(N) : 1,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 10,
  parameter int HOLD_BITS = 8,
  parameter int FCNT_BITS = 16
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,
  input  logic                 s_frame_start,
  input  logic [X_BITS-1:0]    img_cols,
  input  logic [Y_BITS-1:0]    img_rows,
  input  logic [HOLD_BITS-1:0] param_hold,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [X_BITS-1:0]    wr_x,
  input  logic [Y_BITS-1:0]    wr_y,
  input  logic [X_BITS-1:0]    wr_width,
  input  logic [Y_BITS-1:0]    wr_height,
  input  logic                 wr_enable,
  output logic                 enable,
  output logic [X_BITS-1:0]    param_x,
  output logic [Y_BITS-1:0]    param_y,
  output logic [X_BITS-1:0]    param_width,
  output logic [Y_BITS-1:0]    param_height,
  output logic [IDX_BITS-1:0]  region_index,
  output logic [FCNT_BITS-1:0] frame_count
);

  typedef struct packed {
    logic              en;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [X_BITS-1:0] width;
    logic [Y_BITS-1:0] height;
  } entry_t;

  entry_t [N-1:0]             tbl;
  logic   [N-1:0]             elig;
  logic   [N-1:0][X_BITS-1:0] clamp_w;
  logic   [N-1:0][Y_BITS-1:0] clamp_h;
  logic   [HOLD_BITS-1:0]     hold_cnt;

  logic                       found;
  logic   [IDX_BITS-1:0]      sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      jelly3_img_region_rect_scheduler_unit #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
      ) u_unit (
        .en       (tbl[gi].en),
        .x        (tbl[gi].x),
        .y        (tbl[gi].y),
        .width    (tbl[gi].width),
        .height   (tbl[gi].height),
        .img_cols (img_cols),
        .img_rows (img_rows),
        .eligible (elig[gi]),
        .clamp_w  (clamp_w[gi]),
        .clamp_h  (clamp_h[gi])
      );
    end
  endgenerate

  // Round-robin search starting after the active entry. The active entry itself is tried last.
  always_comb begin
    found = 1'b0;
    sel   = region_index;
    for (int k = 1; k <= N; k++) begin
      if (!found && elig[(int'(region_index) + k) % N]) begin
        found = 1'b1;
        sel   = IDX_BITS'((int'(region_index) + k) % N);
      end
    end
  end

  // Table writes and the frame-start update. Selection sees the table as it was before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl          <= '0;
      enable       <= 1'b0;
      param_x      <= '0;
      param_y      <= '0;
      param_width  <= '0;
      param_height <= '0;
      region_index <= IDX_BITS'(N - 1);
      frame_count  <= '0;
      hold_cnt     <= '0;
    end else if (cke) begin
      if (wr_en && (int'(wr_index) < N)) begin
        tbl[wr_index] <= '{en: wr_enable, x: wr_x, y: wr_y, width: wr_width, height: wr_height};
      end
      if (s_frame_start) begin
        frame_count <= frame_count + 1'b1;
        if ((hold_cnt != '0) && elig[region_index]) begin
          // Keep the same entry, but re-clamp against the current image and entry contents.
          hold_cnt     <= hold_cnt - 1'b1;
          param_x      <= tbl[region_index].x;
          param_y      <= tbl[region_index].y;
          param_width  <= clamp_w[region_index];
          param_height <= clamp_h[region_index];
        end else if (found) begin
          enable       <= 1'b1;
          region_index <= sel;
          hold_cnt     <= param_hold;
          param_x      <= tbl[sel].x;
          param_y      <= tbl[sel].y;
          param_width  <= clamp_w[sel];
          param_height <= clamp_h[sel];
        end else begin
          enable   <= 1'b0;
          hold_cnt <= '0;
        end
      end
    end
  end

endmodule
